// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Multi-cycle data memory for the MEM stage; stalls the pipeline
//            for LATENCY cycles, then returns read data or commits a write.
//            Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          mis_q, mis_d;

  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          mis_in;
  logic [AW-1:0] idx_in;
  logic          we;
  logic [AW-1:0] widx;
  logic [31:0]   wdat;
  logic          unused_addr;

  assign req    = memRead_i | memWrite_i;
  assign idx_in = addr_i[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_in = (addr_i[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif

  // Upper address bits are ignored so the index wraps modulo DEPTH.
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      mis_q   <= mis_d;
    end
  end

  // Array contents survive reset by design.
  always_ff @(posedge clk_i) begin
    if (we) mem[widx] <= wdat;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    mis_d      = mis_q;
    ReadData_o = 32'd0;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    we         = 1'b0;
    widx       = idx_q;
    wdat       = wdata_q;

    if (rst_n_i) begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (LATENCY == 0) begin
              done_o     = 1'b1;
              err_o      = mis_in;
              ReadData_o = mis_in ? 32'd0 : mem[idx_in];
              we         = memWrite_i & ~mis_in;
              widx       = idx_in;
              wdat       = WriteData_i;
            end else begin
              stall_o = 1'b1;
              idx_d   = idx_in;
              wdata_d = WriteData_i;
              wr_d    = memWrite_i;
              mis_d   = mis_in;
              cnt_d   = CNT_INIT;
              state_d = (CNT_INIT != 4'd0) ? S_WAIT : S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_d = S_IDLE;
          end else begin
            stall_o = 1'b1;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          // A dropped request here is a flush: no completion, no commit.
          if (req) begin
            done_o     = 1'b1;
            err_o      = mis_q;
            ReadData_o = mis_q ? 32'd0 : mem[idx_q];
            we         = wr_q & ~mis_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// Testbench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance driven
// with directed and random accesses, checked by queue-based scoreboards.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rd_a = 1'b0, wr_a = 1'b0;
  logic [31:0] addr_a = 32'd0, wd_a = 32'd0;
  logic [31:0] rdata_a;
  logic        stall_a, done_a, err_a;

  logic        rd_b = 1'b0, wr_b = 1'b0;
  logic [31:0] addr_b = 32'd0, wd_b = 32'd0;
  logic [31:0] rdata_b;
  logic        stall_b, done_b, err_b;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .memRead_i(rd_a), .memWrite_i(wr_a),
    .addr_i(addr_a), .WriteData_i(wd_a), .ReadData_o(rdata_a),
    .stall_o(stall_a), .done_o(done_a), .err_o(err_a));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .memRead_i(rd_b), .memWrite_i(wr_b),
    .addr_i(addr_b), .WriteData_i(wd_b), .ReadData_o(rdata_b),
    .stall_o(stall_b), .done_o(done_b), .err_o(err_b));

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a, e_b;
  logic [31:0] mem_m [2][DEPTH];
  bit          valid_m [2][DEPTH];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: word-addressed array per instance; reads see the pre-write word.
  function automatic exp_t model_access(input int which, input logic wr,
                                        input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    bit   mis;
    idx   = int'((addr >> 2) % DEPTH);
    mis   = MIS_EN && (addr % 4 != 0);
    e.err  = mis;
    e.data = mis ? 32'd0 : mem_m[which][idx];
    if (wr && !mis) begin
      mem_m[which][idx]   = data;
      valid_m[which][idx] = 1'b1;
    end
    return e;
  endfunction

  function automatic int pick_valid(input int which);
    int idx;
    for (int k = 0; k < 200; k++) begin
      idx = int'($urandom_range(0, DEPTH - 1));
      if (valid_m[which][idx]) return idx;
    end
    for (int k = 0; k < DEPTH; k++) if (valid_m[which][k]) return k;
    return 0;
  endfunction

  function automatic logic [31:0] mk_addr(input int idx, input logic [1:0] lo);
    logic [31:0] hi;
    hi = $urandom;
    return (hi & ~32'(DEPTH * 4 - 1)) | 32'(idx * 4) | {30'd0, lo};
  endfunction

  // Monitors: every completion pops one expected response.
  always @(negedge clk) begin
    if (rst_n && done_a) begin
      if (q_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL done_a: unexpected completion, got done=1, expected 0 (t=%0t)", $time);
      end else begin
        e_a = q_a.pop_front();
        chk("rdata_a", rdata_a, e_a.data);
        chk("err_a", 32'(err_a), 32'(e_a.err));
      end
    end
    if (rst_n && done_b) begin
      if (q_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL done_b: unexpected completion, got done=1, expected 0 (t=%0t)", $time);
      end else begin
        e_b = q_b.pop_front();
        chk("rdata_b", rdata_b, e_b.data);
        chk("err_b", 32'(err_b), 32'(e_b.err));
      end
    end
  end

  task automatic access_a(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data);
    int stalls;
    int cyc;
    bit seen;
    stalls = 0; cyc = 0; seen = 1'b0;
    @(posedge clk); #1;
    rd_a = rd; wr_a = wr; addr_a = addr; wd_a = data;
    q_a.push_back(model_access(0, wr, addr, data));
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (stall_a) stalls++;
      if (done_a) seen = 1'b1;
    end
    chk("done_a_seen", 32'(seen), 32'd1);
    chk("stall_cycles_a", 32'(stalls), 32'(LAT));
    chk("latency_a", 32'(cyc), 32'(LAT + 1));
  endtask

  task automatic idle_a(input int n);
    @(posedge clk); #1;
    rd_a = 1'b0; wr_a = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic cycle_b(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
    @(posedge clk); #1;
    rd_b = rd; wr_b = wr; addr_b = addr; wd_b = data;
    if (rd || wr) q_b.push_back(model_access(1, wr, addr, data));
    @(negedge clk);
    chk("stall_b", 32'(stall_b), 32'd0);
    chk("done_b", 32'(done_b), 32'(rd | wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx;
    bit  w;
    int  cyc;
    bit  seen;

    // Outputs must be quiet during reset even with requests asserted.
    rd_a = 1'b1; rd_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_stall_a", 32'(stall_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_rdata_b", rdata_b, 32'd0);
    chk("rst_done_b", 32'(done_b), 32'd0);
    chk("rst_err_b", 32'(err_b), 32'd0);
    @(posedge clk); #1;
    rd_a = 1'b0; rd_b = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stall_a", 32'(stall_a), 32'd0);
    chk("idle_done_a", 32'(done_a), 32'd0);
    chk("idle_rdata_a", rdata_a, 32'd0);

    // LATENCY=2 directed: basic write/read, misaligned read, index wrap.
    access_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access_a(1'b1, 1'b0, 32'h10, 32'h0);
    access_a(1'b1, 1'b0, 32'h12, 32'h0);
    access_a(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
    access_a(1'b1, 1'b0, 32'h0, 32'h0);
    access_a(1'b1, 1'b1, 32'h10, 32'hCAFEF00D);
    access_a(1'b1, 1'b0, 32'h10, 32'h0);
    idle_a(2);

    // Random accesses, including read+write together and ignored upper bits.
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      idx = w ? int'($urandom_range(0, DEPTH - 1)) : pick_valid(0);
      access_a(w ? 1'($urandom_range(0, 1)) : 1'b1, w, mk_addr(idx, 2'($urandom)), $urandom);
      if ($urandom_range(0, 2) == 0) idle_a(int'($urandom_range(0, 2)));
    end
    idle_a(1);

    // Flush while waiting: no completion, word keeps its old value.
    access_a(1'b0, 1'b1, 32'h8, 32'h11);
    @(posedge clk); #1;
    rd_a = 1'b0; wr_a = 1'b1; addr_a = 32'h8; wd_a = 32'h55;
    @(posedge clk); #1;
    wr_a = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_wait_done_a", 32'(done_a), 32'd0);
    end

    // Flush in the completion cycle.
    @(posedge clk); #1;
    wr_a = 1'b1; addr_a = 32'h8; wd_a = 32'h66;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_a = 1'b0;
    @(negedge clk);
    chk("abort_done_done_a", 32'(done_a), 32'd0);
    chk("abort_done_rdata_a", rdata_a, 32'd0);
    access_a(1'b1, 1'b0, 32'h8, 32'h0);

    // Reset during the wait of a write.
    @(posedge clk); #1;
    rd_a = 1'b0; wr_a = 1'b1; addr_a = 32'h8; wd_a = 32'h77;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall_a", 32'(stall_a), 32'd0);
    chk("midrst_done_a", 32'(done_a), 32'd0);
    chk("midrst_rdata_a", rdata_a, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("postrst_stall_a", 32'(stall_a), 32'd1);
    // The held request is a fresh access; it must see the untouched word.
    q_a.push_back(model_access(0, 1'b1, 32'h8, 32'h77));
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (done_a) seen = 1'b1;
    end
    chk("postrst_done_seen_a", 32'(seen), 32'd1);
    access_a(1'b1, 1'b0, 32'h8, 32'h0);
    idle_a(1);

    // LATENCY=0 instance: single-cycle completions, never stalls.
    cycle_b(1'b0, 1'b1, 32'h20, 32'h1234);
    cycle_b(1'b1, 1'b0, 32'h20, 32'h0);
    chk("l0_read_rdata_b", rdata_b, 32'h1234);
    cycle_b(1'b1, 1'b1, 32'h420, 32'h5678);
    cycle_b(1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: cycle_b(1'b0, 1'b0, 32'h0, 32'h0);
        1: begin
          idx = int'($urandom_range(0, DEPTH - 1));
          cycle_b(1'($urandom_range(0, 1)), 1'b1, mk_addr(idx, 2'($urandom)), $urandom);
        end
        default: begin
          idx = pick_valid(1);
          cycle_b(1'b1, 1'b0, mk_addr(idx, 2'($urandom)), 32'h0);
        end
      endcase
    end
    cycle_b(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    chk("pending_a", 32'(q_a.size()), 32'd0);
    chk("pending_b", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
